// File: rtl/i2c_write_master.sv
// Bit-level I2C write engine: START, three bytes MSB-first each followed by
// an ACK slot, then STOP. Every bus slot is four quarter-bit ticks produced
// by a clock-enable divider running on iCLK.
module i2c_write_master #(
  parameter int CLK_FREQ = 50000000,
  parameter int I2C_FREQ = 20000
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic [23:0] iDATA,
  input  logic        iGO,
  output logic        oEND,
  output logic        oACK,
  output logic        oBUSY,
  output logic        I2C_SCLK,
  inout  wire         I2C_SDAT
);

  localparam int QDIV = CLK_FREQ / (4 * I2C_FREQ);
  localparam int QW   = (QDIV > 1) ? $clog2(QDIV) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_DONE
  } state_t;

  state_t        state_q, state_d;
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0]    phase_q, phase_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    byte_q, byte_d;
  logic [23:0]   shift_q, shift_d;
  logic          scl_q, scl_d;
  logic          sda_lo_q, sda_lo_d;  // 1 = pull SDA low, 0 = release
  logic          nack_q, nack_d;

  logic active;
  logic tick;

  assign active = (state_q != S_IDLE) && (state_q != S_DONE);
  assign tick   = active && (qcnt_q == QW'(QDIV - 1));

  // Open-drain data line: only ever low or released.
  assign I2C_SDAT = sda_lo_q ? 1'b0 : 1'bz;
  assign I2C_SCLK = scl_q;
  assign oBUSY    = active;
  assign oEND     = (state_q == S_DONE);
  assign oACK     = oEND & nack_q;

  // State and bus registers; reset aborts immediately and releases the bus.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state_q  <= S_IDLE;
      qcnt_q   <= '0;
      phase_q  <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      shift_q  <= '0;
      scl_q    <= 1'b1;
      sda_lo_q <= 1'b0;
      nack_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      qcnt_q   <= qcnt_d;
      phase_q  <= phase_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      shift_q  <= shift_d;
      scl_q    <= scl_d;
      sda_lo_q <= sda_lo_d;
      nack_q   <= nack_d;
    end
  end

  // Next-state: divider, phase sequencing and per-slot bus actions on ticks.
  always_comb begin
    state_d  = state_q;
    qcnt_d   = '0;
    phase_d  = '0;
    bit_d    = bit_q;
    byte_d   = byte_q;
    shift_d  = shift_q;
    scl_d    = scl_q;
    sda_lo_d = sda_lo_q;
    nack_d   = nack_q;

    if (active) begin
      qcnt_d  = tick ? '0 : qcnt_q + 1'b1;
      phase_d = tick ? phase_q + 2'd1 : phase_q;
    end

    case (state_q)
      S_IDLE: begin
        // oEND is always low here, so the request level alone starts a transfer.
        if (iGO) begin
          shift_d = iDATA;
          nack_d  = 1'b0;
          state_d = S_START;
        end
      end
      S_START: if (tick) begin
        case (phase_q)
          2'd0: begin scl_d = 1'b1; sda_lo_d = 1'b0; end
          2'd1: sda_lo_d = 1'b1;
          2'd2: scl_d = 1'b0;
          default: begin
            bit_d   = 3'd7;
            byte_d  = 2'd0;
            state_d = S_BIT;
          end
        endcase
      end
      S_BIT: if (tick) begin
        case (phase_q)
          2'd0: begin scl_d = 1'b0; sda_lo_d = ~shift_q[23]; end
          2'd1: scl_d = 1'b1;
          2'd2: ;
          default: begin
            scl_d   = 1'b0;
            shift_d = {shift_q[22:0], 1'b0};
            if (bit_q == 3'd0) state_d = S_ACK;
            else               bit_d   = bit_q - 3'd1;
          end
        endcase
      end
      S_ACK: if (tick) begin
        case (phase_q)
          2'd0: sda_lo_d = 1'b0;
          2'd1: scl_d = 1'b1;
          2'd2: if (I2C_SDAT) nack_d = 1'b1;  // NACK is sticky, no abort
          default: begin
            scl_d = 1'b0;
            if (byte_q == 2'd2) begin
              state_d = S_STOP;
            end else begin
              byte_d  = byte_q + 2'd1;
              bit_d   = 3'd7;
              state_d = S_BIT;
            end
          end
        endcase
      end
      S_STOP: if (tick) begin
        case (phase_q)
          2'd0: begin scl_d = 1'b0; sda_lo_d = 1'b1; end
          2'd1: scl_d = 1'b1;
          2'd2: sda_lo_d = 1'b0;
          default: state_d = S_DONE;
        endcase
      end
      S_DONE: begin
        if (!iGO) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_write_master.sv
// Bench for i2c_write_master: pulled-up SDA, a slave model that collects
// bytes and ACKs per a mask, a scoreboard of expected bytes / NACK flags,
// and a bus protocol monitor.
module tb_i2c_write_master;

  logic        iCLK = 1'b0;
  logic        iRST;
  logic [23:0] iDATA;
  logic        iGO;
  logic        oEND, oACK, oBUSY, I2C_SCLK;
  wire         sda;
  logic        slv_lo = 1'b0;

  assign sda = slv_lo ? 1'b0 : 1'bz;
  pullup (sda);

  i2c_write_master #(.CLK_FREQ(400), .I2C_FREQ(25)) dut (
    .iCLK(iCLK), .iRST(iRST), .iDATA(iDATA), .iGO(iGO),
    .oEND(oEND), .oACK(oACK), .oBUSY(oBUSY),
    .I2C_SCLK(I2C_SCLK), .I2C_SDAT(sda)
  );

  always #5 iCLK = ~iCLK;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  logic [7:0] exp_q[$];
  logic       exp_ack_q[$];

  // Slave / monitor state
  logic [2:0] ack_mask = 3'b111;   // bit i = 1 -> ACK byte i
  int         bit_cnt  = 0;
  int         byte_cnt = 0;
  logic [7:0] shreg    = 8'h00;
  logic       in_ack   = 1'b0;
  logic       bus_act  = 1'b0;
  logic       prev_scl = 1'b1;
  logic       prev_sda = 1'b1;
  int         starts   = 0;
  int         stops    = 0;
  int         viol     = 0;

  // Slave model and protocol monitor, sampled on the falling iCLK edge.
  always @(negedge iCLK) begin
    logic s;
    s = sda;
    if (iRST) begin
      bit_cnt = 0; byte_cnt = 0; in_ack = 0; slv_lo = 0; bus_act = 0;
      exp_q.delete();
    end else begin
      if (prev_scl && I2C_SCLK && (prev_sda != s)) begin
        if (!s) begin
          if (bus_act) viol++;
          starts++; bus_act = 1; bit_cnt = 0; byte_cnt = 0; in_ack = 0;
        end else begin
          if (!bus_act || byte_cnt != 3) viol++;
          stops++; bus_act = 0; slv_lo = 0;
        end
      end else if (!prev_scl && I2C_SCLK && bus_act && !in_ack && bit_cnt < 8 && byte_cnt < 3) begin
        shreg = {shreg[6:0], s};
        bit_cnt++;
        if (bit_cnt == 8) begin
          if (exp_q.size() > 0) chk("byte", {24'h0, shreg}, {24'h0, exp_q.pop_front()});
          else                  chk("byte_unexpected", {24'h0, shreg}, 32'h100);
        end
      end else if (prev_scl && !I2C_SCLK && bus_act) begin
        if (bit_cnt == 8 && !in_ack) begin
          in_ack = 1;
          slv_lo = ack_mask[byte_cnt];
        end else if (in_ack) begin
          in_ack = 0; slv_lo = 0; bit_cnt = 0; byte_cnt++;
        end
      end
    end
    prev_scl = I2C_SCLK;
    prev_sda = s;
  end

  task automatic step();
    @(posedge iCLK); #1;
  endtask

  // One complete transfer; optional iDATA corruption chg_at cycles in.
  task automatic run_xfer(input logic [23:0] w, input logic [2:0] am, input int chg_at);
    int n, t0, st0;
    ack_mask = am;
    iDATA    = w;
    exp_q.push_back(w[23:16]);
    exp_q.push_back(w[15:8]);
    exp_q.push_back(w[7:0]);
    exp_ack_q.push_back(am != 3'b111);
    st0 = stops;
    iGO = 1'b1;
    n = 0;
    while (!oBUSY && n < 50) begin step(); n++; end
    chk("busy_up", {31'h0, oBUSY}, 32'h1);
    t0 = n;
    while (!oEND && n < 2000) begin
      step(); n++;
      if (n == chg_at) iDATA = 24'h000000;
    end
    chk("end_up", {31'h0, oEND}, 32'h1);
    chk("latency", n - t0, 29 * 16);
    chk("nack_flag", {31'h0, oACK}, {31'h0, exp_ack_q.pop_front()});
    chk("busy_dn", {31'h0, oBUSY}, 32'h0);
    chk("stop_seen", stops - st0, 1);
  endtask

  task automatic drop_go();
    iGO = 1'b0;
    step();
    chk("end_clr", {31'h0, oEND}, 32'h0);
    chk("ack_clr", {31'h0, oACK}, 32'h0);
  endtask

  initial begin
    int st, n;
    iRST = 1'b1; iGO = 1'b0; iDATA = 24'h0;
    repeat (3) step();
    chk("rst_scl",  {31'h0, I2C_SCLK}, 32'h1);
    chk("rst_sda",  {31'h0, sda},      32'h1);
    chk("rst_end",  {31'h0, oEND},     32'h0);
    chk("rst_ack",  {31'h0, oACK},     32'h0);
    chk("rst_busy", {31'h0, oBUSY},    32'h0);
    iRST = 1'b0;
    step();

    // all bytes ACKed
    run_xfer(24'hBAF101, 3'b111, 0);

    // GO held after completion: no restart, then registered clear
    st = starts;
    repeat (100) step();
    chk("hold_busy",   {31'h0, oBUSY}, 32'h0);
    chk("hold_end",    {31'h0, oEND},  32'h1);
    chk("hold_starts", starts - st,    0);
    drop_go();

    // slave NACKs byte 1 only; transfer still runs to completion
    run_xfer(24'hBAF101, 3'b101, 0);
    drop_go();

    // iDATA corrupted mid-transfer
    run_xfer(24'hBAF101, 3'b111, 150);
    drop_go();

    // reset during byte 1, bit 4
    ack_mask = 3'b111;
    iDATA = 24'hBAF101;
    exp_q.push_back(8'hBA); exp_q.push_back(8'hF1); exp_q.push_back(8'h01);
    iGO = 1'b1;
    n = 0;
    while (!(byte_cnt == 1 && bit_cnt == 4) && n < 1000) begin step(); n++; end
    chk("abort_reached", {31'h0, (byte_cnt == 1 && bit_cnt == 4)}, 32'h1);
    iRST = 1'b1;
    step();
    chk("abort_scl",  {31'h0, I2C_SCLK}, 32'h1);
    chk("abort_sda",  {31'h0, sda},      32'h1);
    chk("abort_busy", {31'h0, oBUSY},    32'h0);
    chk("abort_end",  {31'h0, oEND},     32'h0);
    iRST = 1'b0;
    run_xfer(24'hBAF101, 3'b111, 0);
    drop_go();

    repeat (20) step();
    chk("proto_viol", viol, 0);
    chk("sb_left", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
